// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data and downstream valid/ready/data.
// master drives the block's inputs (producer/consumer side); slave is the register chain itself.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register chain (STAGES slots) with valid/ready, stall and flush; empty slots carry zero data.
// Optional macro PIPE_SKID_EN adds a one-entry input skid buffer so in_ready has no path from out_ready.
module pipe_stage_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CW     = $clog2(STAGES + 2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  pipe_stage_reg_if.slave bus,
  output logic [CW-1:0]   count
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] vNxt;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  d    [STAGES];
  logic [WIDTH-1:0]  dNxt [STAGES];
  logic              inReady;
  logic              accept;
  logic              srcValid;
  logic [WIDTH-1:0]  srcData;
  logic [CW-1:0]     cntNxt;
  logic              outValid;

`ifdef PIPE_SKID_EN
  logic              skidV;
  logic              skidVNxt;
  logic [WIDTH-1:0]  skidD;
  logic [WIDTH-1:0]  skidDNxt;
`endif

  // Advance ripples from the output back to slot 0: a slot may load if it is
  // empty or the slot ahead of it is moving this cycle.
  always_comb begin
    logic mv;
    adv = '0;
    mv  = bus.out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      adv[STAGES-1-i] = ~stall & (~v[STAGES-1-i] | mv);
      mv              = adv[STAGES-1-i];
    end
  end

`ifdef PIPE_SKID_EN
  assign inReady = ~skidV & ~stall & ~flush;
`else
  assign inReady = ~stall & ~flush & adv[0];
`endif

  assign accept = bus.in_valid & inReady;

  always_comb begin
    srcValid = accept;
    srcData  = accept ? bus.in_data : '0;
`ifdef PIPE_SKID_EN
    skidVNxt = skidV;
    skidDNxt = skidD;
    // The skid entry drains into slot 0 ahead of new input; new input is
    // parked in the skid only when slot 0 cannot take it.
    if (skidV) begin
      srcValid = 1'b1;
      srcData  = skidD;
      if (adv[0]) begin
        skidVNxt = 1'b0;
        skidDNxt = '0;
      end
    end else if (accept && !adv[0]) begin
      skidVNxt = 1'b1;
      skidDNxt = bus.in_data;
    end
    if (flush) begin
      skidVNxt = 1'b0;
      skidDNxt = '0;
    end
`endif

    vNxt    = v;
    dNxt[0] = d[0];
    if (adv[0]) begin
      vNxt[0] = srcValid;
      dNxt[0] = srcData;
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      dNxt[k] = d[k];
      if (adv[k]) begin
        vNxt[k] = v[k-1];
        dNxt[k] = d[k-1];
      end
    end

    if (flush) begin
      vNxt = '0;
      for (int unsigned k = 0; k < STAGES; k++) dNxt[k] = '0;
    end
  end

  always_comb begin
    cntNxt = '0;
    for (int unsigned k = 0; k < STAGES; k++) cntNxt = cntNxt + CW'(vNxt[k]);
`ifdef PIPE_SKID_EN
    cntNxt = cntNxt + CW'(skidVNxt);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= '0;
      count <= '0;
      for (int unsigned k = 0; k < STAGES; k++) d[k] <= '0;
    end else begin
      v     <= vNxt;
      count <= cntNxt;
      for (int unsigned k = 0; k < STAGES; k++) d[k] <= dNxt[k];
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skidV <= 1'b0;
      skidD <= '0;
    end else begin
      skidV <= skidVNxt;
      skidD <= skidDNxt;
    end
  end
`endif

  assign outValid      = v[STAGES-1] & ~stall & ~flush;
  assign bus.out_valid = outValid;
  assign bus.out_data  = outValid ? d[STAGES-1] : '0;
  assign bus.in_ready  = inReady;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (STAGES=3, WIDTH=32): directed stream/backpressure/stall/flush/reset plus random traffic.
// Reference model is a FIFO of held bundles; capacity and in_ready are derived from its occupancy.
module tb_pipe_stage_reg;
  localparam int unsigned S   = 3;
  localparam int unsigned W   = 32;
  localparam int unsigned CW  = $clog2(S + 2);
`ifdef PIPE_SKID_EN
  localparam int unsigned CAP = S + 1;
`else
  localparam int unsigned CAP = S;
`endif

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          flush;
  logic [CW-1:0] count;

  pipe_stage_reg_if #(.WIDTH(W)) bus ();

  pipe_stage_reg #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        checks   = 0;
  int        failures = 0;
  logic [W-1:0] q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, then at +2 check count/in_ready against the
  // model and push the bundle if the handshake completes at the coming edge.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy,
                      input logic st, input logic fl);
    logic expReady;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    stall         = st;
    flush         = fl;
    #2;
    if (rst_n) begin
`ifdef PIPE_SKID_EN
      expReady = ~st & ~fl & (q.size() <= S);
`else
      expReady = ~st & ~fl & ((q.size() < S) | ordy);
`endif
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(bus.in_ready), 64'(expReady));
      if (iv && bus.in_ready) q.push_back(id);
    end
  endtask

  // Monitor: consumes output handshakes and compares against the scoreboard.
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      chk("out_valid_blocked", 64'(bus.out_valid & (stall | flush)), 64'd0);
      if (!bus.out_valid) chk("bubble_zero", 64'(bus.out_data), 64'd0);
      if (bus.out_valid && bus.out_ready && !stall && !flush) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out: got 0x%0h expected no output", bus.out_data);
        end else begin
          chk("out_data", 64'(bus.out_data), 64'(q.pop_front()));
        end
      end
      if (flush) q.delete();
    end
  end

  initial begin
    rst_n         = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Stream with latency check: input in cycle c appears at the output in cycle c+S.
    begin
      logic [W-1:0] exp [3];
      exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
      for (int unsigned c = 0; c < 7; c++) begin
        step(c < 3, (c < 3) ? exp[c] : '0, 1'b1, 1'b0, 1'b0);
        if (c < S) chk("lat_not_yet", 64'(bus.out_valid), 64'd0);
        else if (c < S + 3) begin
          chk("lat_valid", 64'(bus.out_valid), 64'd1);
          chk("lat_data", 64'(bus.out_data), 64'(exp[c-S]));
        end
        if (c == S) chk("count_peak", 64'(count), 64'd3);
      end
    end

    // Backpressure: fill, hold, check full, then release.
    for (int unsigned i = 0; i < CAP + 3; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'(CAP));
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    for (int unsigned i = 0; i < CAP + 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Stall mid-stream.
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 32'h200 + i, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 2; i++) begin
      step(1'b1, 32'h2F0 + i, 1'b1, 1'b1, 1'b0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd0);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    for (int unsigned i = 0; i < 6; i++) step(i < 2, 32'h210 + i, 1'b1, 1'b0, 1'b0);

    // Flush with three held entries, together with a new bundle and out_ready.
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 32'h300 + i, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hAA, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_out_data", 64'(bus.out_data), 64'd0);
    for (int unsigned i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset while full, mid-cycle.
    for (int unsigned i = 0; i < CAP + 1; i++) step(1'b1, 32'h400 + i, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int unsigned i = 0; i < 10000; i++)
      step($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);

    for (int unsigned i = 0; i < 2 * CAP + 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for the five-stage MIPS core: a chain of STAGES slots carrying a WIDTH-bit bundle plus a valid bit, with valid/ready handshake, stall and flush. It generalises the fixed per-stage registers (IF/ID through MEM/WB) into one reusable block. Bubbles are explicit: an empty slot carries valid=0 and an all-zero bundle, so a downstream write-enable packed in the bundle is never asserted. It sits between any two stages and also serves as a multi-cycle delay line for long-latency units.

## Interface
- WIDTH, 32: bit width of the carried bundle (data plus control bits), 1..512.
- STAGES, 1: number of register slots in the chain, 1..8.
- CW, $clog2(STAGES+2): width of the occupancy count (derived; do not override).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream bundle valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  upstream bundle.
- stall  input  1  freeze: no slot moves, nothing accepted, nothing emitted.
- flush  input  1  synchronous kill of every held entry.
- out_valid  output  1  last slot holds a valid bundle.
- out_ready  input  1  downstream consumes the bundle this cycle.
- out_data  output  WIDTH  last-slot bundle; all zero when out_valid=0.
- count  output  CW  number of valid entries held, including the skid entry.

## Operation
- Slot k (0..STAGES-1) holds v[k] and d[k]. Slot STAGES-1 drives out_valid and out_data.
- Handshake: transfer in on in_valid & in_ready; transfer out on out_valid & out_ready & ~stall.
- Advance rule: slot k loads from slot k-1 (slot 0 loads from the input) when ~stall & (~v[k] | move[k]). Here move[STAGES-1] = out_ready, and move[k] = advance of slot k+1. Bubbles collapse, so throughput is one bundle per cycle.
- A slot that empties without refill sets v=0 and d=0.
- Without skid: in_ready = ~stall & ~flush & (~v[0] | advance of slot 0), which is combinational on out_ready.
- flush: at the next edge every v and d is cleared, including the skid entry. In that cycle in_ready=0 and the out_valid handshake is suppressed (out_valid forced 0), so no bundle completes.
- Priority: rst_n > flush > stall > normal advance.
- stall: forces out_valid=0 and in_ready=0. All slots hold.
- count: registered. Updated to popcount of the valid bits (including skid) after each edge.

## Timing
- Reset (rst_n=0, asynchronous): all v=0, d=0, skid empty, count=0, out_valid=0, out_data=0.
- in_ready follows its equation immediately after reset release, which is 1 when stall=0 and flush=0.
- Latency: an accepted bundle reaches out_valid exactly STAGES cycles later if out_ready is held 1 and there is no stall.
- Full: all slots valid and out_ready=0 gives in_ready=0. The next cycle with out_ready=1 gives in_ready=1 in the same cycle (no-skid build).
- Reset mid-operation discards all contents with no partial transfer.
- flush together with a completing out handshake: the output transfer does not happen.

## Configuration
- PIPE_SKID_EN defined: a one-entry skid buffer is added at the input.
  - in_ready = ~skid_v & ~stall & ~flush, a function of registers plus stall/flush only, with no combinational path from out_ready.
  - An accepted bundle that slot 0 cannot take goes to the skid entry.
  - The skid entry drains into slot 0 with priority over new input.
  - Latency is unchanged when the skid is empty. Maximum count is STAGES+1.
- PIPE_SKID_EN undefined: no skid entry, and in_ready is the combinational equation above. Maximum count is STAGES.

## Test plan
- Reset and stream: STAGES=3, WIDTH=32, out_ready=1, inputs 0x11, 0x22, 0x33 on consecutive cycles. Required: out_data 0x11, 0x22, 0x33 on cycles 3, 4, 5; count peaks at 3.
- Backpressure: fill STAGES=2, hold out_ready=0 for 4 cycles. Required: count=2 and in_ready=0 (count=3 and in_ready=0 with PIPE_SKID_EN). On release, order is preserved with no loss or duplicates.
- Stall: assert stall for 2 cycles mid-stream. Required: out_valid=0 and in_ready=0, slot contents unchanged, stream resumes intact.
- Flush: with 3 valid entries, pulse flush together with in_valid=1 and data 0xAA. Required: next cycle count=0, out_valid=0, out_data=0, and 0xAA is never emitted.
- Async reset: drop rst_n mid-clock while full. Required: outputs zero immediately, without waiting for a clock edge.
- Random: random in_valid, out_ready and stall for 10k cycles against a scoreboard. Required: no loss, duplication or reorder, and count matches the model.
